// File: rtl/screen_writer_if.sv
// Byte-stream input, clear request and registered RAM write port of the screen writer.
// The design drives the slave side; the stream source and RAM owner sit on the master side.
interface screen_writer_if #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 16
);
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 clear_req;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic                 we;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output in_valid, in_data, clear_req,
    input  in_ready, addr, wdata, we, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data, clear_req,
    output in_ready, addr, wdata, we, busy, frame_done
  );
endinterface

// File: rtl/screen_writer.sv
// Packs a high-byte-first byte stream into 16-bit words written to consecutive screen RAM
// addresses, and fills the whole RAM with CLEAR_VALUE on request.
module screen_writer #(
  parameter int unsigned          RAM_WIDTH          = 16,
  parameter int unsigned          RAM_REGISTER_COUNT = 256,
  parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE        = 16'h0000
) (
  input  logic          CLK_50,
  input  logic          resetN,
  screen_writer_if.slave bus_io
);
  localparam int unsigned AddrWidth = $clog2(RAM_REGISTER_COUNT);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(RAM_REGISTER_COUNT - 1);

  localparam logic [1:0] S_HI  = 2'd0;
  localparam logic [1:0] S_LO  = 2'd1;
  localparam logic [1:0] S_WR  = 2'd2;
  localparam logic [1:0] S_CLR = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           hi_q, hi_d;
  logic                 pend_q, pend_d;
  logic                 we_q, we_d;
  logic [RAM_WIDTH-1:0] wdata_q, wdata_d;
  logic                 in_ready;
  logic                 accept;

  always_comb begin
    in_ready = resetN && ((state_q == S_HI && !pend_q) || state_q == S_LO);
    accept   = bus_io.in_valid && in_ready;

    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    pend_d   = pend_q;
    we_d     = we_q;
    wdata_d  = wdata_q;

    if (bus_io.clear_req && state_q != S_CLR) pend_d = 1'b1;

    case (state_q)
      S_HI: begin
        // A pending clear wins over a waiting byte; a request arriving now is absorbed.
        if (pend_q) begin
          state_d = S_CLR;
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = CLEAR_VALUE;
          pend_d  = 1'b0;
        end else if (accept) begin
          hi_d    = bus_io.in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = wr_ptr_q;
          wdata_d = {hi_q, bus_io.in_data};
          state_d = S_WR;
        end
      end
      S_WR: begin
        we_d     = 1'b0;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = S_HI;
      end
      S_CLR: begin
        if (addr_q == LastAddr) begin
          we_d     = 1'b0;
          wr_ptr_d = '0;
          state_d  = S_HI;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = S_HI;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (!resetN) begin
      state_q  <= S_HI;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      hi_q     <= '0;
      pend_q   <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.busy       = resetN && (state_q != S_HI || pend_q);
  assign bus_io.frame_done = resetN && state_q == S_WR && addr_q == LastAddr;
  assign bus_io.we         = we_q;
  assign bus_io.addr       = addr_q;
  assign bus_io.wdata      = wdata_q;
endmodule

// File: doc/screen_writer.md
SCREEN_WRITER -- requirements
Module: screen_writer

Interface
REQ-001 Parameter RAM_WIDTH, default 16, data word width of the screen RAM; only 16 is supported.
REQ-002 Parameter RAM_REGISTER_COUNT, default 256, number of RAM words; address width is clog2(RAM_REGISTER_COUNT).
REQ-003 Parameter CLEAR_VALUE, default 16'h0000, word written to every address during a clear.
REQ-004 CLK_50  input  1  single clock; all state changes on the rising edge.
REQ-005 resetN  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data; the high byte of each word is sent first.
REQ-008 in_ready  output  1  byte-stream ready; a byte is accepted on any edge where in_valid and in_ready are both 1.
REQ-009 clear_req  input  1  single-cycle request to fill the whole RAM with CLEAR_VALUE.
REQ-010 addr  output  8  RAM write address, registered.
REQ-011 wdata  output  16  RAM write data, registered.
REQ-012 we  output  1  RAM write enable, registered.
REQ-013 busy  output  1  high when the state is not S_HI or a clear is pending.
REQ-014 frame_done  output  1  one-cycle pulse when a stream write to address 255 is performed.

Function
REQ-015 The FSM SHALL have four states: S_HI (awaiting high byte), S_LO (awaiting low byte), S_WR (write cycle) and S_CLR (clearing).
REQ-016 in_ready SHALL be high only in S_HI with no clear pending, or in S_LO.
REQ-017 S_HI: on an accepted byte, store it in hi_reg and go to S_LO.
REQ-018 S_LO: on an accepted byte, on the same edge set we<=1, addr<=wr_ptr, wdata<={hi_reg,in_data}, and go to S_WR.
REQ-019 Write latency: we SHALL be high in the cycle immediately after the low byte is accepted.
REQ-020 S_WR SHALL last exactly one cycle; on exit, we<=0, wr_ptr<=wr_ptr+1 modulo 256, and the state returns to S_HI.
REQ-021 Peak throughput SHALL be one word per 3 cycles.
REQ-022 wr_ptr SHALL wrap from 255 to 0 with no other effect.
REQ-023 frame_done SHALL be high in the S_WR cycle in which addr==255.
REQ-024 A clear_req pulse in any state other than S_CLR SHALL set clear_pending.
REQ-025 clear_req received while in S_CLR SHALL be ignored.
REQ-026 A clear SHALL NOT abort a half-received word: S_LO completes its byte and its write first.
REQ-027 In S_HI with clear_pending, the FSM SHALL enter S_CLR; this takes priority over in_valid (in_ready is low in that cycle).
REQ-028 On the edge entering S_CLR: we<=1, addr<=0, wdata<=CLEAR_VALUE, clear_pending<=0.
REQ-029 In S_CLR, addr SHALL increment by 1 on each edge.
REQ-030 On the edge where S_CLR has addr==255: we<=0, wr_ptr<=0, and the state returns to S_HI.
REQ-031 we SHALL be high for exactly 256 consecutive cycles per clear.
REQ-032 frame_done SHALL NOT pulse during a clear.
REQ-033 When we is low, addr and wdata SHALL hold their last values.

Reset
REQ-034 While resetN is low at an edge: state<=S_HI, wr_ptr<=0, hi_reg<=0, clear_pending<=0, we<=0, addr<=0, wdata<=0.
REQ-035 While resetN is low, in_ready, busy and frame_done SHALL all be 0.
REQ-036 Reset asserted mid-word or mid-clear SHALL abandon the operation; no write SHALL follow the release of reset.
REQ-037 The first byte after reset release SHALL be treated as a high byte.

Verification
REQ-038 Stream 8'hAB then 8'hCD after reset -> exactly one cycle of we=1, addr=0, wdata=16'hABCD, one cycle after the second byte is accepted; in_ready=0 in that cycle.
REQ-039 Stream 512 bytes, the ith word being {i,~i} -> 256 writes, addresses 0..255 in order; frame_done pulses once, with the write to address 255; the next word goes to address 0.
REQ-040 Pulse clear_req in S_HI -> we=1 for 256 cycles with addr 0..255 and wdata=CLEAR_VALUE; in_ready=0 and busy=1 throughout; the next streamed word goes to address 0.
REQ-041 Pulse clear_req after the high byte 8'h12 is accepted, then send 8'h34 -> write 16'h1234 occurs first, then the 256-cycle clear.
REQ-042 Assert resetN=0 during clear at addr=100 -> we=0 and addr=0 on the next edge; no further writes after release until new bytes arrive.
REQ-043 Hold in_valid=1 with random gaps and a second clear_req during S_CLR -> no byte lost or duplicated, and exactly one clear is performed.
